ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Shared-RAM arbiter between the per-core RAM_CONTROLLER read/write ports and one single-port synchronous data RAM. It collects read requests (address + RR) and write requests (address + data + WR) from up to CORES controllers and serves one access at a time. The winning controller receives ACK plus read data, or ACCESS once its write is committed. It is the stage directly downstream of every core's RAM controller.

## Interface
- CORES, 4, number of attached RAM controllers (2..8)
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width
- CLK  in  1  clock, all state updates on rising edge
- RST_n  in  1  asynchronous, active-low reset
- RAMARBITER_RdReq  in  CORES  per-core read request (controller's RR)
- RAMARBITER_RdAddr  in  CORES*ADDR_W  per-core read address, core k in bits [k*ADDR_W +: ADDR_W]
- RAMARBITER_RdAck  out  CORES  per-core one-cycle read acknowledge
- RAMARBITER_RdData  out  DATA_W  read data, valid only while some RdAck bit is 1
- RAMARBITER_WrReq  in  CORES  per-core write request (controller's WR)
- RAMARBITER_WrAddr  in  CORES*ADDR_W  per-core write address
- RAMARBITER_WrData  in  CORES*DATA_W  per-core write data
- RAMARBITER_WrAccess  out  CORES  per-core one-cycle write-committed pulse
- RAMARBITER_GrantID  out  3  index of core currently being served
- RAM_Addr  out  ADDR_W  RAM address
- RAM_En  out  1  RAM access enable
- RAM_We  out  1  RAM write enable
- RAM_WData  out  DATA_W  RAM write data
- RAM_RData  in  DATA_W  RAM read data, valid one cycle after an enabled read

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: if any RdReq|WrReq bit is set, select a winner core, latch its index, its operation and its address/data, then go to ISSUE. With no request, stay in IDLE.
- Winner selection: round-robin. The search starts at pointer P. After a core k is served, P = (k+1) mod CORES. Reset sets P to 0.
- Same core with both WrReq and RdReq set: the write is served first; the read is served in a later arbitration round.
- ISSUE: RAM_En=1 and RAM_Addr is driven. For a write, RAM_We=1 and RAM_WData is driven, then go to DONE. For a read, RAM_We=0, then go to WAIT.
- WAIT (read only): capture RAM_RData into the RdData register, then go to DONE.
- DONE: pulse RdAck[k] (read) or WrAccess[k] (write) for exactly one cycle, advance P, return to IDLE.
- Requester rule: a controller holds its request, address and data stable until its ACK/ACCESS pulse, and drops the request in the next cycle. A request still high in the IDLE cycle after DONE is treated as a new request.
- Requests from non-winning cores stay pending and are never dropped. A request deasserted before it is granted is ignored.

## Timing
- Reset value of every output: RdAck=0, WrAccess=0, RdData=0, GrantID=0, RAM_En=0, RAM_We=0, RAM_Addr=0, RAM_WData=0. FSM goes to IDLE and P to 0.
- Read: request sampled in IDLE at cycle 0; ISSUE at cycle 1; WAIT at cycle 2; RdAck and RdData at cycle 3. Latency is 3 cycles, and a new arbitration happens at cycle 4.
- Write: request sampled in IDLE at cycle 0; ISSUE with RAM_We at cycle 1; WrAccess at cycle 2. Latency is 2 cycles, and a new arbitration happens at cycle 3.
- Peak throughput: one read per 4 cycles, or one write per 3 cycles.
- RAM_En and RAM_We are high only during ISSUE.
- GrantID is updated on the IDLE→ISSUE transition and holds until the next grant.
- Reset asserted mid-access: all outputs clear immediately (asynchronously). The access in flight gets no ACK/ACCESS, and a write already issued to the RAM may or may not have been committed.
- The round-robin pointer wraps from CORES-1 to 0.

## Configuration
- RAM_ARBITER_FIXED_PRIORITY_EN defined: P is held at 0, so the lowest-numbered requesting core always wins. Starvation of high-index cores is possible.
- RAM_ARBITER_FIXED_PRIORITY_EN undefined (default): round-robin as specified above.

## Test plan
- Single read, core 2, addr 0x1234, RAM preloaded with 0x5A -> RAM_Addr=0x1234 with RAM_En=1 at cycle 1; RdAck=4'b0100 and RdData=0x5A at cycle 3.
- Single write, core 1, addr 0x0010, data 0xC3 -> RAM_We=1 at cycle 1; WrAccess=4'b0010 at cycle 2; a later read of 0x0010 returns 0xC3.
- All 4 cores issue reads at once, requests held until ACK -> ACKs arrive in order core 0,1,2,3, four cycles apart. With FIXED_PRIORITY_EN and core 0 re-requesting each time, core 0 is served repeatedly and core 3 never is.
- Core 0 raises WrReq (0x0020←0x11) and RdReq (0x0020) together -> WrAccess first, then a read returning 0x11.
- Reset pulled low in the WAIT cycle of a read -> no RdAck; all outputs are 0 immediately. After release, the still-held request is served with full 3-cycle latency.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the per-core RAM controllers, the shared-RAM arbiter and
// the single-port synchronous data RAM.
interface ram_arbiter_if #(
    parameter int CORES  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // Handshake: a controller raises RdReq/WrReq with address/data stable and
    // holds them until its one-cycle RdAck/WrAccess pulse, then drops the
    // request; a request still high in the following IDLE cycle is a new one.
    logic [CORES-1:0]        RAMARBITER_RdReq;
    logic [CORES*ADDR_W-1:0] RAMARBITER_RdAddr;
    logic [CORES-1:0]        RAMARBITER_RdAck;
    logic [DATA_W-1:0]       RAMARBITER_RdData;
    logic [CORES-1:0]        RAMARBITER_WrReq;
    logic [CORES*ADDR_W-1:0] RAMARBITER_WrAddr;
    logic [CORES*DATA_W-1:0] RAMARBITER_WrData;
    logic [CORES-1:0]        RAMARBITER_WrAccess;
    logic [2:0]              RAMARBITER_GrantID;
    logic [ADDR_W-1:0]       RAM_Addr;
    logic                    RAM_En;
    logic                    RAM_We;
    logic [DATA_W-1:0]       RAM_WData;
    logic [DATA_W-1:0]       RAM_RData;
    logic [1:0]              dbg_state;

    modport slave (
        input  RAMARBITER_RdReq, RAMARBITER_RdAddr,
        input  RAMARBITER_WrReq, RAMARBITER_WrAddr, RAMARBITER_WrData,
        input  RAM_RData,
        output RAMARBITER_RdAck, RAMARBITER_RdData, RAMARBITER_WrAccess,
        output RAMARBITER_GrantID,
        output RAM_Addr, RAM_En, RAM_We, RAM_WData,
        output dbg_state
    );

    modport master (
        output RAMARBITER_RdReq, RAMARBITER_RdAddr,
        output RAMARBITER_WrReq, RAMARBITER_WrAddr, RAMARBITER_WrData,
        output RAM_RData,
        input  RAMARBITER_RdAck, RAMARBITER_RdData, RAMARBITER_WrAccess,
        input  RAMARBITER_GrantID,
        input  RAM_Addr, RAM_En, RAM_We, RAM_WData,
        input  dbg_state
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serving one RAM access at a time for up to CORES controllers.
// Define RAM_ARBITER_FIXED_PRIORITY_EN to pin the search start at core 0.
module ram_arbiter #(
    parameter int CORES  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic         CLK,
    input  logic         RST_n,
    ram_arbiter_if.slave bus
);
    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nx;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nx;
    logic [IDX_W-1:0]    r_grant, w_grant_nx;
    logic [IDX_W-1:0]    w_win, w_idx, w_ptr_inc;
    logic                r_is_wr, w_is_wr_nx;
    logic [CORES-1:0]    w_req;
    logic [CORES-1:0]    r_rd_ack, w_rd_ack_nx;
    logic [CORES-1:0]    r_wr_access, w_wr_access_nx;
    logic                r_ram_en, w_ram_en_nx;
    logic                r_ram_we, w_ram_we_nx;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nx;
    logic [DATA_W-1:0]   r_ram_wdata, w_ram_wdata_nx;
    logic [DATA_W-1:0]   r_rd_data, w_rd_data_nx;
    logic                w_found;
    int                  w_sum;

    assign w_req = bus.RAMARBITER_RdReq | bus.RAMARBITER_WrReq;

    // First requester found when scanning upward from the pointer, with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = 0;
        w_idx   = '0;
        for (int i = 0; i < CORES; i++) begin
            w_sum = int'(r_ptr) + i;
            if (w_sum >= CORES) begin
                w_sum = w_sum - CORES;
            end
            w_idx = IDX_W'(w_sum);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_ptr_inc = (r_grant == IDX_W'(CORES - 1)) ? '0 : r_grant + IDX_W'(1);

    always_comb begin
        w_state_nx      = r_state;
        w_ptr_nx        = r_ptr;
        w_grant_nx      = r_grant;
        w_is_wr_nx      = r_is_wr;
        w_ram_en_nx     = 1'b0;
        w_ram_we_nx     = 1'b0;
        w_ram_addr_nx   = r_ram_addr;
        w_ram_wdata_nx  = r_ram_wdata;
        w_rd_data_nx    = r_rd_data;
        w_rd_ack_nx     = '0;
        w_wr_access_nx  = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nx  = ISSUE;
                    w_grant_nx  = w_win;
                    // A pending write beats a read from the same core.
                    w_is_wr_nx  = bus.RAMARBITER_WrReq[w_win];
                    w_ram_en_nx = 1'b1;
                    w_ram_we_nx = bus.RAMARBITER_WrReq[w_win];
                    if (bus.RAMARBITER_WrReq[w_win]) begin
                        w_ram_addr_nx  = bus.RAMARBITER_WrAddr[w_win*ADDR_W +: ADDR_W];
                        w_ram_wdata_nx = bus.RAMARBITER_WrData[w_win*DATA_W +: DATA_W];
                    end else begin
                        w_ram_addr_nx  = bus.RAMARBITER_RdAddr[w_win*ADDR_W +: ADDR_W];
                    end
                end
            end
            ISSUE: begin
                if (r_is_wr) begin
                    w_state_nx              = DONE;
                    w_wr_access_nx[r_grant] = 1'b1;
                end else begin
                    w_state_nx = WAIT;
                end
            end
            WAIT: begin
                w_state_nx           = DONE;
                w_rd_data_nx         = bus.RAM_RData;
                w_rd_ack_nx[r_grant] = 1'b1;
            end
            DONE: begin
                w_state_nx = IDLE;
`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
                w_ptr_nx   = '0;
`else
                w_ptr_nx   = w_ptr_inc;
`endif
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_is_wr     <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_rd_data   <= '0;
            r_rd_ack    <= '0;
            r_wr_access <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_grant     <= w_grant_nx;
            r_is_wr     <= w_is_wr_nx;
            r_ram_en    <= w_ram_en_nx;
            r_ram_we    <= w_ram_we_nx;
            r_ram_addr  <= w_ram_addr_nx;
            r_ram_wdata <= w_ram_wdata_nx;
            r_rd_data   <= w_rd_data_nx;
            r_rd_ack    <= w_rd_ack_nx;
            r_wr_access <= w_wr_access_nx;
        end
    end

    assign bus.RAMARBITER_RdAck    = r_rd_ack;
    assign bus.RAMARBITER_RdData   = r_rd_data;
    assign bus.RAMARBITER_WrAccess = r_wr_access;
    assign bus.RAMARBITER_GrantID  = 3'(r_grant);
    assign bus.RAM_Addr            = r_ram_addr;
    assign bus.RAM_En              = r_ram_en;
    assign bus.RAM_We              = r_ram_we;
    assign bus.RAM_WData           = r_ram_wdata;
    assign bus.dbg_state           = r_state;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed-vector bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;
    localparam int CORES = 4;
    localparam int AW    = 16;
    localparam int DW    = 8;
`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.CORES(CORES), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.CORES(CORES), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    // Behavioural single-port RAM: read data appears the cycle after an enabled read.
    logic [7:0] mem [logic [15:0]];
    logic [7:0] ram_rdata = 8'h00;
    assign bus.RAM_RData = ram_rdata;

    function automatic logic [7:0] preload(input logic [15:0] a);
        case (a)
            16'h1234: return 8'h5A;
            16'h0000: return 8'h99;
            default:  return 8'hA0 + a[7:0];
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.RAM_En) begin
            if (bus.RAM_We) mem[bus.RAM_Addr] = bus.RAM_WData;
            else ram_rdata <= mem.exists(bus.RAM_Addr) ? mem[bus.RAM_Addr] : preload(bus.RAM_Addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " RdAck"},    32'(bus.RAMARBITER_RdAck),    32'h0);
        check({tag, " WrAccess"}, 32'(bus.RAMARBITER_WrAccess), 32'h0);
        check({tag, " RdData"},   32'(bus.RAMARBITER_RdData),   32'h0);
        check({tag, " GrantID"},  32'(bus.RAMARBITER_GrantID),  32'h0);
        check({tag, " RAM_En"},   32'(bus.RAM_En),              32'h0);
        check({tag, " RAM_We"},   32'(bus.RAM_We),              32'h0);
        check({tag, " RAM_Addr"}, 32'(bus.RAM_Addr),            32'h0);
        check({tag, " RAM_WData"},32'(bus.RAM_WData),           32'h0);
    endtask

    task automatic set_rd(input int k, input logic [15:0] a, input logic on);
        bus.RAMARBITER_RdAddr[k*AW +: AW] = a;
        bus.RAMARBITER_RdReq[k]           = on;
    endtask

    task automatic set_wr(input int k, input logic [15:0] a, input logic [7:0] d, input logic on);
        bus.RAMARBITER_WrAddr[k*AW +: AW] = a;
        bus.RAMARBITER_WrData[k*DW +: DW] = d;
        bus.RAMARBITER_WrReq[k]           = on;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         core;
        bit         is_wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  exp_pulse;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t        vecs [8];
    logic [11:0] exp_q [$];

    initial begin
        logic [11:0] e;
        int          n_got;
        int          exp_core;
        bit          w_seen;
        bit          r_seen;

        vecs[0] = '{2, 1'b0, 16'h1234, 8'h00, 4'b0100, 8'h5A};
        vecs[1] = '{1, 1'b1, 16'h0010, 8'hC3, 4'b0010, 8'h00};
        vecs[2] = '{0, 1'b0, 16'h0010, 8'h00, 4'b0001, 8'hC3};
        vecs[3] = '{3, 1'b1, 16'hFFFF, 8'h7E, 4'b1000, 8'h00};
        vecs[4] = '{3, 1'b0, 16'hFFFF, 8'h00, 4'b1000, 8'h7E};
        vecs[5] = '{1, 1'b0, 16'h0000, 8'h00, 4'b0010, 8'h99};
        vecs[6] = '{2, 1'b1, 16'h0000, 8'h3C, 4'b0100, 8'h00};
        vecs[7] = '{2, 1'b0, 16'h0000, 8'h00, 4'b0100, 8'h3C};

        rst_n = 1'b0;
        bus.RAMARBITER_RdReq  = '0;
        bus.RAMARBITER_WrReq  = '0;
        bus.RAMARBITER_RdAddr = '0;
        bus.RAMARBITER_WrAddr = '0;
        bus.RAMARBITER_WrData = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset state", 32'(bus.dbg_state), 32'h0);
        rst_n = 1'b1;

        // Single accesses: exact cycle-by-cycle timing.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk);
            #1;
            if (vecs[v].is_wr) set_wr(vecs[v].core, vecs[v].addr, vecs[v].wdata, 1'b1);
            else set_rd(vecs[v].core, vecs[v].addr, 1'b1);
            @(negedge clk);
            check($sformatf("v%0d c0 En", v), 32'(bus.RAM_En), 32'h0);
            @(negedge clk);
            check($sformatf("v%0d c1 En", v), 32'(bus.RAM_En), 32'h1);
            check($sformatf("v%0d c1 We", v), 32'(bus.RAM_We), 32'(vecs[v].is_wr));
            check($sformatf("v%0d c1 Addr", v), 32'(bus.RAM_Addr), 32'(vecs[v].addr));
            check($sformatf("v%0d c1 Grant", v), 32'(bus.RAMARBITER_GrantID), 32'(vecs[v].core));
            if (vecs[v].is_wr)
                check($sformatf("v%0d c1 WData", v), 32'(bus.RAM_WData), 32'(vecs[v].wdata));
            @(negedge clk);
            check($sformatf("v%0d c2 En", v), 32'(bus.RAM_En), 32'h0);
            if (vecs[v].is_wr) begin
                check($sformatf("v%0d c2 WrAccess", v), 32'(bus.RAMARBITER_WrAccess), 32'(vecs[v].exp_pulse));
                check($sformatf("v%0d c2 RdAck", v), 32'(bus.RAMARBITER_RdAck), 32'h0);
                set_wr(vecs[v].core, vecs[v].addr, vecs[v].wdata, 1'b0);
            end else begin
                check($sformatf("v%0d c2 RdAck", v), 32'(bus.RAMARBITER_RdAck), 32'h0);
                @(negedge clk);
                check($sformatf("v%0d c3 RdAck", v), 32'(bus.RAMARBITER_RdAck), 32'(vecs[v].exp_pulse));
                check($sformatf("v%0d c3 RdData", v), 32'(bus.RAMARBITER_RdData), 32'(vecs[v].exp_rdata));
                set_rd(vecs[v].core, vecs[v].addr, 1'b0);
            end
            @(negedge clk);
            check($sformatf("v%0d pulse width", v),
                  32'(bus.RAMARBITER_RdAck | bus.RAMARBITER_WrAccess), 32'h0);
        end

        // All four cores read at once from a reset pointer: served 0,1,2,3 four cycles apart.
        pulse_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < CORES; k++) begin
            set_rd(k, 16'h0100 + 16'(k), 1'b1);
            exp_q.push_back({4'(k), 8'hA0 + 8'(k)});
        end
        n_got = 0;
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            if (bus.RAMARBITER_RdAck != '0) begin
                e = exp_q.pop_front();
                check($sformatf("A ack %0d onehot", n_got), 32'(bus.RAMARBITER_RdAck), 32'(1) << e[11:8]);
                check($sformatf("A ack %0d data", n_got), 32'(bus.RAMARBITER_RdData), 32'(e[7:0]));
                check($sformatf("A ack %0d cycle", n_got), 32'(cyc), 32'(3 + 4 * n_got));
                for (int k = 0; k < CORES; k++)
                    if (bus.RAMARBITER_RdAck[k]) bus.RAMARBITER_RdReq[k] = 1'b0;
                n_got++;
            end
        end
        check("A all acks", 32'(exp_q.size()), 32'h0);

        // Core 0 keeps re-requesting: round-robin still reaches 1,2,3; fixed priority does not.
        @(posedge clk);
        #1;
        for (int k = 0; k < CORES; k++) set_rd(k, 16'h0100 + 16'(k), 1'b1);
        n_got = 0;
        for (int cyc = 0; cyc < 40 && n_got < 4; cyc++) begin
            @(negedge clk);
            if (bus.RAMARBITER_RdAck != '0) begin
                exp_core = FIXED ? 0 : n_got;
                check($sformatf("B ack %0d onehot", n_got), 32'(bus.RAMARBITER_RdAck), 32'(1) << exp_core);
                check($sformatf("B ack %0d data", n_got), 32'(bus.RAMARBITER_RdData), 32'(8'hA0 + 8'(exp_core)));
                for (int k = 1; k < CORES; k++)
                    if (bus.RAMARBITER_RdAck[k]) bus.RAMARBITER_RdReq[k] = 1'b0;
                n_got++;
                if (n_got == 4) bus.RAMARBITER_RdReq = '0;
            end
        end
        check("B ack count", 32'(n_got), 32'h4);
        repeat (6) @(negedge clk);
        check("B idle En", 32'(bus.RAM_En), 32'h0);
        check("B idle state", 32'(bus.dbg_state), 32'h0);

        // Same core, write and read together: write first, then read returns the new value.
        @(posedge clk);
        #1;
        set_wr(0, 16'h0020, 8'h11, 1'b1);
        set_rd(0, 16'h0020, 1'b1);
        w_seen = 1'b0;
        r_seen = 1'b0;
        for (int cyc = 0; cyc < 14 && !r_seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check("C c1 We", 32'(bus.RAM_We), 32'h1);
            if (bus.RAMARBITER_WrAccess != '0) begin
                w_seen = 1'b1;
                check("C WrAccess", 32'(bus.RAMARBITER_WrAccess), 32'h1);
                check("C WrAccess cycle", 32'(cyc), 32'h2);
                bus.RAMARBITER_WrReq[0] = 1'b0;
            end
            if (bus.RAMARBITER_RdAck != '0) begin
                r_seen = 1'b1;
                check("C RdAck", 32'(bus.RAMARBITER_RdAck), 32'h1);
                check("C RdAck cycle", 32'(cyc), 32'h6);
                check("C RdData", 32'(bus.RAMARBITER_RdData), 32'h11);
                bus.RAMARBITER_RdReq[0] = 1'b0;
            end
        end
        check("C write seen", 32'(w_seen), 32'h1);
        check("C read seen", 32'(r_seen), 32'h1);
        repeat (2) @(negedge clk);

        // Reset during WAIT: no ack, outputs clear at once, held request re-served afterwards.
        @(posedge clk);
        #1;
        set_rd(2, 16'h1234, 1'b1);
        repeat (2) @(negedge clk);
        check("D c1 En", 32'(bus.RAM_En), 32'h1);
        @(negedge clk);
        check("D c2 state WAIT", 32'(bus.dbg_state), 32'h2);
        rst_n = 1'b0;
        #1;
        check_all_zero("D async");
        @(negedge clk);
        check("D in reset RdAck", 32'(bus.RAMARBITER_RdAck), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("D re c1 En", 32'(bus.RAM_En), 32'h1);
        check("D re c1 Addr", 32'(bus.RAM_Addr), 32'h1234);
        @(negedge clk);
        check("D re c2 RdAck", 32'(bus.RAMARBITER_RdAck), 32'h0);
        @(negedge clk);
        check("D re c3 RdAck", 32'(bus.RAMARBITER_RdAck), 32'h4);
        check("D re c3 RdData", 32'(bus.RAMARBITER_RdData), 32'h5A);
        set_rd(2, 16'h1234, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end
endmodule
